// File: rtl/bnn_pkg.sv
// Shared constants, FSM encoding and record type for the 8-8-4 BNN datapath.
package bnn_pkg;

  localparam int unsigned NUM_NEURONS = 20;
  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned WEIGHT_W    = 8;
  localparam int unsigned THRESH_W    = 4;
  localparam int unsigned NIB_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GOT_W0 = 2'd1,
    GOT_W1 = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [WEIGHT_W-1:0] weight;
    logic [THRESH_W-1:0] thresh;
  } param_rec_t;

endpackage

// File: rtl/bnn_param_loader_if.sv
// Nibble stream in, parameter register-file write port out.
interface bnn_param_loader_if;
  import bnn_pkg::*;

  logic                load_en;
  logic [NIB_W-1:0]    nibble_in;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WEIGHT_W-1:0] wr_weight;
  logic [THRESH_W-1:0] wr_thresh;

  modport master (
    output load_en, nibble_in,
    input  wr_en, wr_addr, wr_weight, wr_thresh
  );

  modport slave (
    input  load_en, nibble_in,
    output wr_en, wr_addr, wr_weight, wr_thresh
  );

endinterface

// File: rtl/bnn_nibble_assembler.sv
// Latches the two weight nibbles of a record and presents the complete
// {weight, threshold} record alongside the threshold nibble.
module bnn_nibble_assembler
  import bnn_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             acc_w0,
  input  logic             acc_w1,
  input  logic             acc_th,
  input  logic [NIB_W-1:0] nibble,
  output param_rec_t       rec_c,
  output logic             rec_done_c
);

  logic [NIB_W-1:0] w_lo;
  logic [NIB_W-1:0] w_hi;

  // Partial record storage; cleared on reset or load restart.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      w_lo <= '0;
      w_hi <= '0;
    end else begin
      if (acc_w0) w_lo <= nibble;
      if (acc_w1) w_hi <= nibble;
    end
  end

  assign rec_c.weight = WEIGHT_W'({w_hi, w_lo});
  assign rec_c.thresh = THRESH_W'(nibble);
  assign rec_done_c   = acc_th;

endmodule

// File: rtl/bnn_param_loader.sv
// Deserialises the nibble stream into per-neuron records and writes them,
// tracking load pointer, completion and overrun.
module bnn_param_loader
  import bnn_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              clear_ptr,
  bnn_param_loader_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [ADDR_W-1:0] neuron_cnt
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);
  localparam logic [ADDR_W-1:0] FULL_CNT = ADDR_W'(NUM_NEURONS);

  state_t              state_q;
  state_t              state_d;
  logic                clear_c;
  logic                accept_c;
  logic                acc_w0_c;
  logic                acc_w1_c;
  logic                acc_th_c;
  logic                ovr_set_c;
  logic [ADDR_W-1:0]   cnt_d;
  param_rec_t          rec_c;
  logic                rec_done_c;

  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [WEIGHT_W-1:0] wr_weight_q;
  logic [THRESH_W-1:0] wr_thresh_q;

  bnn_nibble_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clr        (clear_c),
    .acc_w0     (acc_w0_c),
    .acc_w1     (acc_w1_c),
    .acc_th     (acc_th_c),
    .nibble     (bus.nibble_in),
    .rec_c      (rec_c),
    .rec_done_c (rec_done_c)
  );

  // Next-state, accept qualification and counter update; clear beats a nibble.
  always_comb begin
    clear_c   = ena && clear_ptr;
    accept_c  = ena && bus.load_en && !clear_ptr;
    state_d   = state_q;
    acc_w0_c  = 1'b0;
    acc_w1_c  = 1'b0;
    acc_th_c  = 1'b0;
    ovr_set_c = 1'b0;
    cnt_d     = neuron_cnt;

    if (clear_c) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept_c) begin
      case (state_q)
        IDLE: begin
          acc_w0_c = 1'b1;
          state_d  = GOT_W0;
        end
        GOT_W0: begin
          acc_w1_c = 1'b1;
          state_d  = GOT_W1;
        end
        GOT_W1: begin
          acc_th_c = 1'b1;
          state_d  = (neuron_cnt == LAST_IDX) ? DONE : IDLE;
          if (neuron_cnt != FULL_CNT) cnt_d = neuron_cnt + ADDR_W'(1);
        end
        DONE: begin
          ovr_set_c = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      neuron_cnt  <= '0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_weight_q <= '0;
      wr_thresh_q <= '0;
    end else begin
      state_q    <= state_d;
      neuron_cnt <= cnt_d;
      done       <= (cnt_d == FULL_CNT);
      overrun    <= clear_c ? 1'b0 : (overrun | ovr_set_c);
      busy       <= (state_d == GOT_W0) || (state_d == GOT_W1);
      // Single-cycle strobe, independent of ena so it always drops.
      wr_en_q    <= rec_done_c;
      if (rec_done_c) begin
        wr_addr_q   <= neuron_cnt;
        wr_weight_q <= rec_c.weight;
        wr_thresh_q <= rec_c.thresh;
      end
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_weight = wr_weight_q;
  assign bus.wr_thresh = wr_thresh_q;

endmodule

// File: tb/tb_bnn_param_loader.sv
// Directed bench for bnn_param_loader: vector table plus multi-cycle sequences.
module tb_bnn_param_loader;
  import bnn_pkg::*;

  logic              clk;
  logic              reset;
  logic              ena;
  logic              clear_ptr;
  logic              busy;
  logic              done;
  logic              overrun;
  logic [ADDR_W-1:0] neuron_cnt;

  bnn_param_loader_if bus ();

  bnn_param_loader dut (
    .clk        (clk),
    .reset      (reset),
    .ena        (ena),
    .clear_ptr  (clear_ptr),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .neuron_cnt (neuron_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot: {wr_en, wr_addr, wr_weight, wr_thresh, busy, done, overrun, neuron_cnt}
  typedef logic [25:0] snap_t;

  typedef struct {
    logic       ena;
    logic       ld;
    logic       clr;
    logic [3:0] nib;
    snap_t      exp;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  function automatic snap_t mk(input logic wr, input logic [4:0] addr, input logic [7:0] w,
                               input logic [3:0] t, input logic b, input logic d,
                               input logic o, input logic [4:0] c);
    return {wr, addr, w, t, b, d, o, c};
  endfunction

  function automatic snap_t snap();
    return {bus.wr_en, bus.wr_addr, bus.wr_weight, bus.wr_thresh, busy, done, overrun, neuron_cnt};
  endfunction

  task automatic check(input string name, input snap_t exp);
    snap_t act;
    act = snap();
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %07h expected %07h", name, act, exp);
  endtask

  task automatic step(input logic e, input logic l, input logic c, input logic [3:0] n);
    ena           = e;
    bus.load_en   = l;
    clear_ptr     = c;
    bus.nibble_in = n;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 4'h0);
    reset = 1'b0;
  endtask

  vec_t vt[25];

  initial begin
    reset         = 1'b0;
    ena           = 1'b0;
    clear_ptr     = 1'b0;
    bus.load_en   = 1'b0;
    bus.nibble_in = 4'h0;
    #2;
    do_reset();
    check("reset_state", mk(0, 0, 8'h00, 4'h0, 0, 0, 0, 0));

    // ena, ld, clr, nib, expected snapshot after the edge
    vt[0]  = '{1, 1, 0, 4'h0, mk(0, 0, 8'h00, 4'h0, 1, 0, 0, 0)};
    vt[1]  = '{1, 1, 0, 4'hF, mk(0, 0, 8'h00, 4'h0, 1, 0, 0, 0)};
    vt[2]  = '{1, 1, 0, 4'h5, mk(1, 0, 8'hF0, 4'h5, 0, 0, 0, 1)};
    vt[3]  = '{1, 0, 0, 4'h0, mk(0, 0, 8'hF0, 4'h5, 0, 0, 0, 1)};
    vt[4]  = '{1, 1, 0, 4'h2, mk(0, 0, 8'hF0, 4'h5, 1, 0, 0, 1)};
    vt[5]  = '{1, 1, 0, 4'h3, mk(0, 0, 8'hF0, 4'h5, 1, 0, 0, 1)};
    vt[6]  = '{1, 1, 1, 4'h4, mk(0, 0, 8'hF0, 4'h5, 0, 0, 0, 0)};
    vt[7]  = '{1, 1, 0, 4'h6, mk(0, 0, 8'hF0, 4'h5, 1, 0, 0, 0)};
    vt[8]  = '{1, 1, 0, 4'h7, mk(0, 0, 8'hF0, 4'h5, 1, 0, 0, 0)};
    vt[9]  = '{1, 1, 0, 4'h8, mk(1, 0, 8'h76, 4'h8, 0, 0, 0, 1)};
    vt[10] = '{0, 1, 0, 4'h9, mk(0, 0, 8'h76, 4'h8, 0, 0, 0, 1)};
    vt[11] = '{0, 1, 1, 4'h9, mk(0, 0, 8'h76, 4'h8, 0, 0, 0, 1)};
    vt[12] = '{1, 0, 1, 4'h0, mk(0, 0, 8'h76, 4'h8, 0, 0, 0, 0)};
    vt[13] = '{1, 1, 0, 4'h1, mk(0, 0, 8'h76, 4'h8, 1, 0, 0, 0)};
    vt[14] = '{1, 1, 0, 4'h2, mk(0, 0, 8'h76, 4'h8, 1, 0, 0, 0)};
    vt[15] = '{1, 1, 0, 4'h3, mk(1, 0, 8'h21, 4'h3, 0, 0, 0, 1)};
    vt[16] = '{1, 0, 1, 4'h0, mk(0, 0, 8'h21, 4'h3, 0, 0, 0, 0)};
    vt[17] = '{1, 1, 0, 4'h4, mk(0, 0, 8'h21, 4'h3, 1, 0, 0, 0)};
    vt[18] = '{1, 1, 0, 4'h5, mk(0, 0, 8'h21, 4'h3, 1, 0, 0, 0)};
    vt[19] = '{1, 1, 0, 4'h6, mk(1, 0, 8'h54, 4'h6, 0, 0, 0, 1)};
    vt[20] = '{0, 0, 0, 4'h0, mk(0, 0, 8'h54, 4'h6, 0, 0, 0, 1)};
    vt[21] = '{1, 1, 0, 4'hA, mk(0, 0, 8'h54, 4'h6, 1, 0, 0, 1)};
    vt[22] = '{1, 1, 0, 4'hB, mk(0, 0, 8'h54, 4'h6, 1, 0, 0, 1)};
    vt[23] = '{1, 1, 0, 4'hC, mk(1, 1, 8'hBA, 4'hC, 0, 0, 0, 2)};
    vt[24] = '{1, 0, 0, 4'h0, mk(0, 1, 8'hBA, 4'hC, 0, 0, 0, 2)};

    for (int i = 0; i < 25; i++) begin
      step(vt[i].ena, vt[i].ld, vt[i].clr, vt[i].nib);
      check($sformatf("vec%0d", i), vt[i].exp);
    end

    // Full load of all neurons, back-to-back
    do_reset();
    check("reset_before_full", mk(0, 0, 8'h00, 4'h0, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      logic [7:0] w;
      w = 8'(i);
      step(1'b1, 1'b1, 1'b0, w[3:0]);
      step(1'b1, 1'b1, 1'b0, w[7:4]);
      step(1'b1, 1'b1, 1'b0, w[3:0]);
      check($sformatf("full_wr%0d", i),
            mk(1, 5'(i), w, w[3:0], 0, (i == 19), 0, 5'(i + 1)));
    end
    step(1'b1, 1'b0, 1'b0, 4'h0);
    check("full_done", mk(0, 19, 8'h13, 4'h3, 0, 1, 0, 20));

    // Nibble after completion is an overrun; clear restarts
    step(1'b1, 1'b1, 1'b0, 4'hA);
    check("overrun_set", mk(0, 19, 8'h13, 4'h3, 0, 1, 1, 20));
    step(1'b1, 1'b0, 1'b0, 4'h0);
    check("overrun_sticky", mk(0, 19, 8'h13, 4'h3, 0, 1, 1, 20));
    step(1'b1, 1'b0, 1'b1, 4'h0);
    check("clear_after_done", mk(0, 19, 8'h13, 4'h3, 0, 0, 0, 0));

    // Gap then ena low with load_en high; nothing accepted until ena returns
    step(1'b1, 1'b1, 1'b0, 4'hB);
    step(1'b1, 1'b1, 1'b0, 4'hD);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 4'h0);
    check("gap_hold", mk(0, 19, 8'h13, 4'h3, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'hE);
      check($sformatf("ena_low%0d", i), mk(0, 19, 8'h13, 4'h3, 1, 0, 0, 0));
    end
    step(1'b1, 1'b1, 1'b0, 4'h9);
    check("gap_write", mk(1, 0, 8'hDB, 4'h9, 0, 0, 0, 1));

    // Reset mid-record discards the partial record
    do_reset();
    step(1'b1, 1'b1, 1'b0, 4'h1);
    step(1'b1, 1'b1, 1'b0, 4'h2);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 4'h0);
    reset = 1'b0;
    check("reset_mid_record", mk(0, 0, 8'h00, 4'h0, 0, 0, 0, 0));
    step(1'b1, 1'b1, 1'b0, 4'h3);
    step(1'b1, 1'b1, 1'b0, 4'hC);
    check("post_reset_busy", mk(0, 0, 8'h00, 4'h0, 1, 0, 0, 0));
    step(1'b1, 1'b1, 1'b0, 4'h7);
    check("post_reset_write", mk(1, 0, 8'hC3, 4'h7, 0, 0, 0, 1));
    step(1'b1, 1'b0, 1'b0, 4'h0);
    check("post_reset_idle", mk(0, 0, 8'hC3, 4'h7, 0, 0, 0, 1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
